// File: rtl/rx_timer_pkg.sv
// rx_timer shared types and default parameters.
// Optional resync feature: RX_TIMER_RESYNC_EN.
package rx_timer_pkg;

    localparam int DEF_CLKS_PER_BIT  = 8;
    localparam int DEF_SAMPLE_POINT  = 3;
    localparam int DEF_BITS_PER_BYTE = 8;
    localparam int CNT_BITS          = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TIMING    = 2'd1,
        BYTE_DONE = 2'd2
    } rx_state_e;

endpackage

// File: rtl/rx_timer_flex_counter.sv
// Generic rollover counter used by rx_timer.
// Counts 1..rollover_val; clear wins over count_enable.
module flex_counter
    import rx_timer_pkg::*;
#(
    parameter int NUM_CNT_BITS = CNT_BITS
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    // Next count: clear, hold, increment or wrap back to 1.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q >= rollover_val) begin
                count_d = NUM_CNT_BITS'(1);
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/rx_timer.sv
// Serial receive bit/byte timer.
// Define RX_TIMER_RESYNC_EN to let d_edge re-centre bit timing.
module rx_timer
    import rx_timer_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
    parameter int SAMPLE_POINT  = DEF_SAMPLE_POINT,
    parameter int BITS_PER_BYTE = DEF_BITS_PER_BYTE
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable_timer,
    input  logic       d_edge,
    input  logic       clear_byte,
    output logic       shift_enable,
    output logic       byte_received,
    output logic [3:0] bit_count
);

    localparam logic [3:0] CLK_ROLL = 4'(CLKS_PER_BIT);
    localparam logic [3:0] SMP_CNT  = 4'(SAMPLE_POINT);
    localparam logic [3:0] BIT_ROLL = 4'(BITS_PER_BYTE);

    rx_state_e  state_q;
    rx_state_e  state_d;
    logic [3:0] clk_cnt;
    logic       abort;
    logic       resync;
    logic       clk_clear;
    logic       bit_clear;

    assign abort = ~enable_timer | clear_byte;

`ifdef RX_TIMER_RESYNC_EN
    assign resync = d_edge & (state_q == TIMING);
`else
    // Edges have no timing effect in this build.
    assign resync = d_edge & 1'b0;
`endif

    assign clk_clear = abort | resync;
    assign bit_clear = abort | (state_q == BYTE_DONE);

    // The strobe comes straight off the count so a
    // coincident resync edge cannot swallow it.
    assign shift_enable = (clk_cnt == SMP_CNT)
                        & enable_timer
                        & ~clear_byte;

    assign byte_received = (state_q == BYTE_DONE);

    flex_counter #(
        .NUM_CNT_BITS (CNT_BITS)
    ) u_clk_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clk_clear),
        .count_enable (enable_timer),
        .rollover_val (CLK_ROLL),
        .count_out    (clk_cnt)
    );

    flex_counter #(
        .NUM_CNT_BITS (CNT_BITS)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (bit_clear),
        .count_enable (shift_enable),
        .rollover_val (BIT_ROLL),
        .count_out    (bit_count)
    );

    // Next state: abort returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = TIMING;
                end
                TIMING: begin
                    if (bit_count == BIT_ROLL) begin
                        state_d = BYTE_DONE;
                    end
                end
                BYTE_DONE: begin
                    state_d = TIMING;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: doc/rx_timer.md
RX_TIMER -- requirements
Module: rx_timer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8, sets clocks per serial bit period (legal 2..15).
REQ-002 Parameter SAMPLE_POINT, default 3, sets the clock-counter value at which a bit is sampled (legal 1..CLKS_PER_BIT).
REQ-003 Parameter BITS_PER_BYTE, default 8, sets bits per received byte (legal 1..15).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 n_rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 enable_timer  input  1  high while a packet is being received; low stops and clears timing.
REQ-007 d_edge  input  1  one-cycle pulse marking a line transition, from the upstream edge detector.
REQ-008 clear_byte  input  1  synchronous abort of the current byte.
REQ-009 shift_enable  output  1  one-cycle strobe telling the downstream shift register to sample a bit.
REQ-010 byte_received  output  1  one-cycle pulse after BITS_PER_BYTE bits have been sampled.
REQ-011 bit_count  output  4  bits sampled in the current byte, 0..BITS_PER_BYTE.

Function
REQ-012 FSM states: IDLE, TIMING, BYTE_DONE; IDLE->TIMING when enable_timer=1; TIMING->BYTE_DONE when bit_count reaches BITS_PER_BYTE; BYTE_DONE->TIMING unconditionally next cycle; any state->IDLE when enable_timer=0 or clear_byte=1.
REQ-013 Clock counter: flex_counter, rollover_val=CLKS_PER_BIT, count_enable=enable_timer; sequence 1,2,..,CLKS_PER_BIT,1,...
REQ-014 Clock counter first reads 1 in the cycle after enable_timer is sampled high.
REQ-015 shift_enable=1 exactly in cycles where clock count==SAMPLE_POINT and enable_timer=1 and clear_byte=0; otherwise 0.
REQ-016 Bit counter: flex_counter, count_enable=shift_enable, increments one cycle after each shift_enable.
REQ-017 byte_received=1 for exactly the BYTE_DONE cycle, i.e. one cycle after bit_count becomes BITS_PER_BYTE.
REQ-018 Bit counter cleared in BYTE_DONE; bit_count reads 0 the following cycle; clock counter keeps running across byte boundaries.
REQ-019 enable_timer=0 or clear_byte=1 clears both counters synchronously (bit_count=0 next cycle); clear has priority over count_enable.
REQ-020 clear_byte coincident with the 8th shift_enable: shift_enable suppressed, no byte_received.
REQ-021 d_edge ignored in IDLE and BYTE_DONE.

Reset
REQ-022 n_rst=0 immediately forces state=IDLE, both counters=0, shift_enable=0, byte_received=0, bit_count=0.
REQ-023 Reset deasserted mid-byte: operation resumes from IDLE; no partial-byte pulse emitted.

Configuration
REQ-024 Macro RX_TIMER_RESYNC_EN: when defined, d_edge in TIMING clears the clock counter so the next shift_enable occurs SAMPLE_POINT+1 cycles after the d_edge cycle; bit_count unaffected.
REQ-025 RX_TIMER_RESYNC_EN defined, d_edge coincident with a shift_enable cycle: that shift_enable still asserts, then the clear applies.
REQ-026 Without RX_TIMER_RESYNC_EN, d_edge has no effect and the clock counter free-runs while enabled.

Structure
REQ-027 Package rx_timer_pkg holds the state enum type and default CLKS_PER_BIT/SAMPLE_POINT/BITS_PER_BYTE constants.
REQ-028 Two instances of existing sub-module flex_counter (NUM_CNT_BITS=4): clock counter and bit counter; FSM and strobe logic in rx_timer.

Verification
REQ-029 Reset: n_rst=0 mid-count -> all outputs 0 same cycle, bit_count=0, state IDLE.
REQ-030 Defaults, enable_timer=1 from cycle 0 -> shift_enable at cycles 3,11,19,...,59; byte_received at cycle 61; bit_count 0 at cycle 62.
REQ-031 enable_timer dropped after 3 shift_enable pulses -> bit_count=0 next cycle, no byte_received, restart gives first shift_enable 3 cycles after re-enable.
REQ-032 clear_byte on cycle of 8th shift_enable -> no shift_enable, no byte_received, bit_count=0 next cycle.
REQ-033 RESYNC_EN, d_edge at clock count 6 -> next shift_enable 4 cycles later; without macro -> next shift_enable at regular 8-cycle spacing.
REQ-034 Two back-to-back bytes -> byte_received pulses exactly 64 cycles apart, bit_count sequence 0..8,0..8.
